// File: rtl/s2c_req_arbiter.sv
// ----------------------------------------------------------------------------
// s2c_req_arbiter
//
// Shares one S2C get-data bridge (id, fn -> ret + DATA_SIZE data words)
// between NUM_REQ requesters. Round-robin grant, a single transaction in
// flight, bridge handshake sequencing and routing of response beats back to
// the granted requester.
//
// Optional feature: define S2C_ARB_TIMEOUT_EN to build in a watchdog. It
// aborts a transaction that stalls for TIMEOUT cycles in ISSUE or DATA,
// returning one error beat (ret = all ones, data = 0, last = 1).
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   req_i         per-requester request level
//   fn_i          per-requester function code, slice k = requester k
//   gnt_o         one-hot grant, held for the whole transaction
//   rsp_valid_o   response beat valid (for the requester in gnt_o)
//   rsp_last_o    final beat of the transaction
//   rsp_ret_o     return code, constant across beats
//   rsp_data_o    data word of the current beat
//   busy_o        transaction in progress
//   br_req_o      bridge request level
//   br_id_o       granted requester index
//   br_fn_o       function code of the granted requester
//   br_ack_i      bridge accepts request, br_ret_i valid this cycle
//   br_ret_i      bridge return code
//   br_dvalid_i   bridge data beat valid
//   br_data_i     bridge data word
// ----------------------------------------------------------------------------
module s2c_req_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [NUM_REQ*32-1:0]      fn_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic                       rsp_valid_o,
   output logic                       rsp_last_o,
   output logic [31:0]                rsp_ret_o,
   output logic [31:0]                rsp_data_o,
   output logic                       busy_o,
   output logic                       br_req_o,
   output logic [$clog2(NUM_REQ)-1:0] br_id_o,
   output logic [31:0]                br_fn_o,
   input  logic                       br_ack_i,
   input  logic [31:0]                br_ret_i,
   input  logic                       br_dvalid_i,
   input  logic [31:0]                br_data_i
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned CW  = $clog2(DATA_SIZE + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DATA,
      DONE
   } state_t;

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [CW-1:0]   cnt;
   logic [31:0]     ret_q;

   logic            win_vld;
   logic [IDW-1:0]  win_idx;
   logic [IDW-1:0]  nxt_rr;
   logic            beat_last;

`ifdef S2C_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]   tmo_cnt;
   logic            tmo_hit;

   // Fires on the TIMEOUT-th consecutive stalled cycle.
   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
`else
   // TIMEOUT only matters when the watchdog is built in.
   if (TIMEOUT == 0) begin : g_no_watchdog
   end
`endif

   // First requester at or after the round-robin pointer, wrapping.
   always_comb begin : pick
      int unsigned k;
      win_vld = 1'b0;
      win_idx = '0;
      k       = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k = 32'(rr_ptr) + i;
         if (k >= NUM_REQ)
            k = k - NUM_REQ;
         if (!win_vld && req_i[k[IDW-1:0]]) begin
            win_vld = 1'b1;
            win_idx = k[IDW-1:0];
         end
      end
   end

   // Pointer value once the current winner has been served.
   always_comb begin
      nxt_rr = '0;
      if (br_id_o != IDW'(NUM_REQ - 1))
         nxt_rr = br_id_o + 1'b1;
   end

   assign beat_last = (cnt == CW'(DATA_SIZE - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         cnt         <= '0;
         ret_q       <= '0;
         gnt_o       <= '0;
         rsp_valid_o <= 1'b0;
         rsp_last_o  <= 1'b0;
         rsp_ret_o   <= '0;
         rsp_data_o  <= '0;
         busy_o      <= 1'b0;
         br_req_o    <= 1'b0;
         br_id_o     <= '0;
         br_fn_o     <= '0;
`ifdef S2C_ARB_TIMEOUT_EN
         tmo_cnt     <= '0;
`endif
      end else begin
         // Beat strobes are single-cycle pulses.
         rsp_valid_o <= 1'b0;
         rsp_last_o  <= 1'b0;

         case (state)
            IDLE: begin
`ifdef S2C_ARB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               if (win_vld) begin
                  gnt_o    <= NUM_REQ'(1) << win_idx;
                  br_id_o  <= win_idx;
                  br_fn_o  <= fn_i[32*win_idx +: 32];
                  br_req_o <= 1'b1;
                  busy_o   <= 1'b1;
                  state    <= ISSUE;
               end
            end

            ISSUE: begin
               if (br_ack_i) begin
                  ret_q    <= br_ret_i;
                  br_req_o <= 1'b0;
                  cnt      <= '0;
                  rr_ptr   <= nxt_rr;
                  state    <= DATA;
`ifdef S2C_ARB_TIMEOUT_EN
                  tmo_cnt  <= '0;
               end else if (tmo_hit) begin
                  br_req_o    <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_last_o  <= 1'b1;
                  rsp_ret_o   <= '1;
                  rsp_data_o  <= '0;
                  rr_ptr      <= nxt_rr;
                  state       <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
`endif
               end
            end

            DATA: begin
               if (br_dvalid_i) begin
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= br_data_i;
                  rsp_ret_o   <= ret_q;
                  rsp_last_o  <= beat_last;
                  cnt         <= cnt + 1'b1;
                  if (beat_last)
                     state <= DONE;
`ifdef S2C_ARB_TIMEOUT_EN
                  tmo_cnt <= '0;
               end else if (tmo_hit) begin
                  rsp_valid_o <= 1'b1;
                  rsp_last_o  <= 1'b1;
                  rsp_ret_o   <= '1;
                  rsp_data_o  <= '0;
                  rr_ptr      <= nxt_rr;
                  state       <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
`endif
               end
            end

            DONE: begin
               gnt_o  <= '0;
               busy_o <= 1'b0;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_s2c_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_s2c_req_arbiter
//
// Self-checking bench for s2c_req_arbiter. The bench plays the bridge and the
// requesters. A table of transactions covers reset, single request,
// contention, beat gaps with stray beats and dropped requests; hand-written
// sequences cover reset mid-transaction and the watchdog; a randomized run
// uses a distance-based round-robin model to predict each winner.
// ----------------------------------------------------------------------------
module tb_s2c_req_arbiter;

   localparam int N  = 4;
   localparam int DS = 8;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req_i = '0;
   logic [N*32-1:0]   fn_i = '0;
   logic [N-1:0]      gnt_o;
   logic              rsp_valid_o;
   logic              rsp_last_o;
   logic [31:0]       rsp_ret_o;
   logic [31:0]       rsp_data_o;
   logic              busy_o;
   logic              br_req_o;
   logic [1:0]        br_id_o;
   logic [31:0]       br_fn_o;
   logic              br_ack_i = 1'b0;
   logic [31:0]       br_ret_i = '0;
   logic              br_dvalid_i = 1'b0;
   logic [31:0]       br_data_i = '0;

   int checks = 0;
   int errors = 0;
   int rr_m   = 0;

   typedef struct {
      logic [N-1:0] req;
      bit           drop;
      int           ackdly;
      int           gap;
      logic [31:0]  ret;
      logic [31:0]  base;
      int           win;
   } txn_t;

   txn_t tbl [12];

   s2c_req_arbiter #(
      .NUM_REQ   (N),
      .DATA_SIZE (DS),
      .TIMEOUT   (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .fn_i        (fn_i),
      .gnt_o       (gnt_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_last_o  (rsp_last_o),
      .rsp_ret_o   (rsp_ret_o),
      .rsp_data_o  (rsp_data_o),
      .busy_o      (busy_o),
      .br_req_o    (br_req_o),
      .br_id_o     (br_id_o),
      .br_fn_o     (br_fn_o),
      .br_ack_i    (br_ack_i),
      .br_ret_i    (br_ret_i),
      .br_dvalid_i (br_dvalid_i),
      .br_data_i   (br_data_i)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_fn();
      for (int k = 0; k < N; k++)
         fn_i[k*32 +: 32] = 32'h14 + k;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},   32'(gnt_o), 0);
      chk({tag, "_vld"},   32'(rsp_valid_o), 0);
      chk({tag, "_last"},  32'(rsp_last_o), 0);
      chk({tag, "_ret"},   rsp_ret_o, 0);
      chk({tag, "_data"},  rsp_data_o, 0);
      chk({tag, "_busy"},  32'(busy_o), 0);
      chk({tag, "_brreq"}, 32'(br_req_o), 0);
      chk({tag, "_brid"},  32'(br_id_o), 0);
      chk({tag, "_brfn"},  br_fn_o, 0);
   endtask

   // Round-robin winner: the requesting index nearest at/after rr, wrapping.
   function automatic int pick(input logic [N-1:0] req, input int rr);
      int best  = -1;
      int bestd = N;
      for (int k = 0; k < N; k++) begin
         if (req[k]) begin
            int d;
            d = (k - rr + N) % N;
            if (d < bestd) begin
               bestd = d;
               best  = k;
            end
         end
      end
      return best;
   endfunction

   // Called at a negedge with the arbiter idle; runs one full transaction.
   task automatic run_txn(input txn_t t);
      int w;
      w     = t.win;
      req_i = t.req;
      step();
      chk("grant",     32'(gnt_o), 1 << w);
      chk("br_id",     32'(br_id_o), w);
      chk("br_fn",     br_fn_o, 32'h14 + w);
      chk("br_req_on", 32'(br_req_o), 1);
      chk("busy_on",   32'(busy_o), 1);
      chk("idle_stray",32'(rsp_valid_o), 0);
      fn_i = {N{32'hDEAD_BEEF}};
      if (t.drop)
         req_i = t.req & ~(N'(1) << w);
      for (int i = 0; i < t.ackdly; i++) begin
         br_dvalid_i = 1'b1;
         br_data_i   = 32'hBAD;
         step();
         chk("issue_hold",  32'(br_req_o), 1);
         chk("issue_stray", 32'(rsp_valid_o), 0);
      end
      br_ack_i    = 1'b1;
      br_ret_i    = t.ret;
      br_dvalid_i = 1'b1;
      br_data_i   = 32'hBAD0;
      step();
      chk("ack_drop",  32'(br_req_o), 0);
      chk("ack_stray", 32'(rsp_valid_o), 0);
      chk("fn_held",   br_fn_o, 32'h14 + w);
      br_ack_i    = 1'b0;
      br_ret_i    = ~t.ret;
      br_dvalid_i = 1'b0;
      for (int b = 0; b < DS; b++) begin
         for (int g = 0; g < t.gap; g++) begin
            br_dvalid_i = 1'b0;
            step();
            chk("gap_vld", 32'(rsp_valid_o), 0);
         end
         br_dvalid_i = 1'b1;
         br_data_i   = t.base + b;
         step();
         br_dvalid_i = 1'b0;
         chk("beat_vld",  32'(rsp_valid_o), 1);
         chk("beat_data", rsp_data_o, t.base + b);
         chk("beat_ret",  rsp_ret_o, t.ret);
         chk("beat_last", 32'(rsp_last_o), (b == DS - 1) ? 1 : 0);
         chk("beat_gnt",  32'(gnt_o), 1 << w);
      end
      // Stray beat while finishing, then one more while idle.
      br_dvalid_i = 1'b1;
      br_data_i   = 32'hBAD1;
      step();
      chk("done_stray", 32'(rsp_valid_o), 0);
      chk("gnt_clear",  32'(gnt_o), 0);
      chk("busy_clear", 32'(busy_o), 0);
      br_data_i = 32'hBAD2;
      set_fn();
      rr_m = (w + 1) % N;
   endtask

   initial begin
      tbl[0]  = '{4'b1111, 1'b0, 0, 0, 32'h0000_0100, 32'h0000_1000, 0};
      tbl[1]  = '{4'b1111, 1'b0, 1, 0, 32'h0000_0101, 32'h0000_2000, 1};
      tbl[2]  = '{4'b1111, 1'b0, 0, 1, 32'h0000_0102, 32'h0000_3000, 2};
      tbl[3]  = '{4'b1111, 1'b0, 2, 0, 32'h0000_0103, 32'h0000_4000, 3};
      tbl[4]  = '{4'b1111, 1'b0, 0, 0, 32'h0000_0104, 32'h0000_5000, 0};
      tbl[5]  = '{4'b0010, 1'b0, 0, 0, 32'h0000_0000, 32'h0000_00A0, 1};
      tbl[6]  = '{4'b1001, 1'b0, 0, 0, 32'h1234_5678, 32'h0000_6000, 3};
      tbl[7]  = '{4'b0101, 1'b0, 0, 3, 32'hCAFE_0001, 32'h0000_7000, 0};
      tbl[8]  = '{4'b0100, 1'b1, 1, 1, 32'h0000_0202, 32'h0000_8000, 2};
      tbl[9]  = '{4'b1100, 1'b0, 0, 0, 32'h0000_0303, 32'h0000_9000, 3};
      tbl[10] = '{4'b0011, 1'b0, 0, 2, 32'h0000_0404, 32'h0000_A000, 0};
      tbl[11] = '{4'b0110, 1'b0, 3, 0, 32'h0000_0505, 32'h0000_B000, 1};

      set_fn();
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();
      chk_all_zero("idle");

      for (int r = 0; r < 12; r++)
         run_txn(tbl[r]);

      // Reset while the fourth beat is arriving; priority restarts at 0.
      req_i = 4'b0001;
      br_dvalid_i = 1'b0;
      step();
      chk("abort_grant", 32'(gnt_o), 1);
      br_ack_i = 1'b1;
      br_ret_i = 32'h55;
      step();
      br_ack_i = 1'b0;
      for (int b = 0; b < 3; b++) begin
         br_dvalid_i = 1'b1;
         br_data_i   = 32'hE0 + b;
         step();
         chk("abort_beat", 32'(rsp_valid_o), 1);
      end
      br_data_i = 32'hE3;
      rst = 1'b1;
      step();
      chk_all_zero("midrst");
      rst = 1'b0;
      br_dvalid_i = 1'b0;
      rr_m = 0;
      run_txn('{4'b1111, 1'b0, 0, 0, 32'h0000_0777, 32'h0000_C000, 0});

`ifdef S2C_ARB_TIMEOUT_EN
      // No ack: watchdog drops the request after TO cycles and returns an error beat.
      req_i = 4'b0110;
      br_dvalid_i = 1'b0;
      step();
      chk("tmo_grant", 32'(gnt_o), 32'b0010);
      chk("tmo_req0",  32'(br_req_o), 1);
      for (int i = 1; i < TO; i++) begin
         step();
         chk("tmo_wait_req", 32'(br_req_o), 1);
         chk("tmo_wait_vld", 32'(rsp_valid_o), 0);
      end
      step();
      chk("tmo_req_drop", 32'(br_req_o), 0);
      chk("tmo_vld",      32'(rsp_valid_o), 1);
      chk("tmo_last",     32'(rsp_last_o), 1);
      chk("tmo_ret",      rsp_ret_o, 32'hFFFF_FFFF);
      chk("tmo_data",     rsp_data_o, 0);
      step();
      chk("tmo_gnt_clear", 32'(gnt_o), 0);
      chk("tmo_busy_clear",32'(busy_o), 0);
      rr_m = 2;
`else
      // Without the watchdog a long ack stall just keeps waiting in ISSUE.
      run_txn('{4'b0110, 1'b0, 40, 0, 32'h0000_0888, 32'h0000_D000, 1});
`endif
      run_txn('{4'b0110, 1'b0, 0, 0, 32'h0000_0999, 32'h0000_E000, 2});

      for (int n = 0; n < 24; n++) begin
         txn_t t;
         t.req    = 4'($urandom_range(1, 15));
         t.drop   = 1'($urandom_range(0, 1));
         t.ackdly = $urandom_range(0, 5);
         t.gap    = $urandom_range(0, 3);
         t.ret    = $urandom;
         t.base   = $urandom;
         t.win    = pick(t.req, rr_m);
         run_txn(t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
